// File: rtl/cdb_arbiter.sv
// Common Data Bus arbiter: one pending result slot per functional unit, round-robin
// selection among occupied slots, registered broadcast of the winner.

module cdb_slot #(
  parameter int DATA_W = 32,
  parameter int TAG_W  = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load,
  input  logic              grant,
  input  logic [TAG_W-1:0]  tag_in,
  input  logic [DATA_W-1:0] data_in,
  output logic              v,
  output logic [TAG_W-1:0]  tag,
  output logic [DATA_W-1:0] data
);
  // A load takes priority over a grant: the old entry leaves on the bus while the new one lands.
  // Tag 0 means "no producer", so such a result is swallowed and the slot stays empty.
  always_ff @(posedge clk) begin
    if (!rst_n)     v <= 1'b0;
    else if (load)  v <= |tag_in;
    else if (grant) v <= 1'b0;
  end

  always_ff @(posedge clk) begin
    if (load) begin
      tag  <= tag_in;
      data <= data_in;
    end
  end
endmodule

module cdb_arbiter #(
  parameter int NUM_FU = 3,
  parameter int DATA_W = 32,
  parameter int TAG_W  = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [NUM_FU-1:0]        fu_valid,
  input  logic [NUM_FU*TAG_W-1:0]  fu_tag,
  input  logic [NUM_FU*DATA_W-1:0] fu_data,
  output logic [NUM_FU-1:0]        fu_ready,
  output logic                     cdb_valid,
  output logic [TAG_W-1:0]         cdb_tag,
  output logic [DATA_W-1:0]        cdb_data,
  output logic [1:0]               cdb_src
);
  localparam int PTR_W = $clog2(NUM_FU);

  logic [NUM_FU-1:0]             pend_v, grant, load;
  logic [NUM_FU-1:0][TAG_W-1:0]  pend_tag;
  logic [NUM_FU-1:0][DATA_W-1:0] pend_data;
  logic [PTR_W-1:0]              rr_ptr, gidx, idx;
  logic                          any_grant;
  int                            sum;

  assign fu_ready = {NUM_FU{rst_n}} & (~pend_v | grant);
  assign load     = fu_valid & fu_ready;

  for (genvar i = 0; i < NUM_FU; i++) begin : g_slot
    cdb_slot #(.DATA_W(DATA_W), .TAG_W(TAG_W)) u_slot (
      .clk     (clk),
      .rst_n   (rst_n),
      .load    (load[i]),
      .grant   (grant[i]),
      .tag_in  (fu_tag[i*TAG_W +: TAG_W]),
      .data_in (fu_data[i*DATA_W +: DATA_W]),
      .v       (pend_v[i]),
      .tag     (pend_tag[i]),
      .data    (pend_data[i])
    );
  end

  // Scan from rr_ptr with wrap; first occupied slot wins.
  always_comb begin
    grant     = '0;
    gidx      = '0;
    idx       = '0;
    sum       = 0;
    any_grant = 1'b0;
    for (int off = 0; off < NUM_FU; off++) begin
      sum = int'(rr_ptr) + off;
      if (sum >= NUM_FU) sum = sum - NUM_FU;
      idx = PTR_W'(sum);
      if (!any_grant && pend_v[idx]) begin
        any_grant   = 1'b1;
        grant[idx]  = 1'b1;
        gidx        = idx;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rr_ptr <= '0;
    end else if (any_grant) begin
      rr_ptr <= (gidx == PTR_W'(NUM_FU-1)) ? '0 : gidx + 1'b1;
    end
  end

  // Tag/data/src hold their last values on idle cycles.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cdb_valid <= 1'b0;
      cdb_tag   <= '0;
      cdb_data  <= '0;
      cdb_src   <= '0;
    end else begin
      cdb_valid <= any_grant;
      if (any_grant) begin
        cdb_tag  <= pend_tag[gidx];
        cdb_data <= pend_data[gidx];
        cdb_src  <= 2'(gidx);
      end
    end
  end
endmodule
